// File: rtl/aes_en_iter.sv
// Iterative AES encryptor: one 128-bit state register, ROUNDS_PER_CYCLE rounds per clock, valid/ready on both sides.
// Optional macro AES_EN_ITER_KEY_REG_EN registers the key at acceptance so the source may drop it afterwards.
module aes_en_iter #(
  parameter int LEN_KEY          = 128,
  parameter int NUM_ROUND        = 10,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       data_in,
  input  logic [LEN_KEY-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       data_out,
  output logic               busy
);

  localparam int RW = $clog2(NUM_ROUND + 1);
  localparam int NK = LEN_KEY / 32;
  localparam int NW = 4 * (NUM_ROUND + 1);
  localparam int KW = 128 * (NUM_ROUND + 1);
  localparam logic [RW-1:0] STEP = RW'(ROUNDS_PER_CYCLE);
  localparam logic [RW-1:0] LAST = RW'(NUM_ROUND - ROUNDS_PER_CYCLE);

  if (NUM_ROUND % ROUNDS_PER_CYCLE != 0) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must divide NUM_ROUND");
  end
  if (!((LEN_KEY == 128 && NUM_ROUND == 10) || (LEN_KEY == 192 && NUM_ROUND == 12) ||
        (LEN_KEY == 256 && NUM_ROUND == 14))) begin : g_bad_key
    $error("LEN_KEY/NUM_ROUND must be 128/10, 192/12 or 256/14");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of a block sits at [127-8n -: 8]; columns are groups of four consecutive bytes.
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int n = 0; n < 16; n++) b[n] = sbox(s[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = t[n] ^ rk[127-8*n -: 8];
    return res;
  endfunction

  function automatic logic [KW-1:0] expand_key(input logic [LEN_KEY-1:0] k);
    logic [31:0]   w [NW];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [KW-1:0] ka;
    rc = 8'h01;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = k[LEN_KEY-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (NK > 6 && i % NK == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-NK] ^ t;
      end
    end
    for (int r = 0; r <= NUM_ROUND; r++)
      ka[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ka;
  endfunction

  // Round key for unrolled slot j is rk[rnd + j + 1]; out-of-range selections read as zero.
  function automatic logic [127:0] pick_rk(input logic [KW-1:0] ka, input logic [RW-1:0] rnd,
                                           input int j);
    logic [127:0] res;
    res = '0;
    for (int r = j + 1; r <= NUM_ROUND; r++)
      if (rnd == RW'(r - j - 1)) res = ka[r*128 +: 128];
    return res;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t               fsm_reg;
  logic [RW-1:0]      rnd_reg;
  logic [127:0]       state_reg;
  logic [LEN_KEY-1:0] key_src;
  logic [KW-1:0]      key_all;
  logic [127:0]       rk_sel [ROUNDS_PER_CYCLE];
  logic [127:0]       round_next;

`ifdef AES_EN_ITER_KEY_REG_EN
  logic [LEN_KEY-1:0] key_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_reg <= '0;
    else if (fsm_reg == IDLE && in_valid) key_reg <= key;
  end
  assign key_src = key_reg;
`else
  assign key_src = key;
`endif

  assign key_all = expand_key(key_src);

  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_rk_mux
    assign rk_sel[gi] = pick_rk(key_all, rnd_reg, gi);
  end

  always_comb begin
    round_next = state_reg;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
      round_next = enc_round(round_next, rk_sel[j], rnd_reg == RW'(NUM_ROUND - 1 - j));
  end

  // rk[0] is the leading 128 key bits, so the initial whitening reads the port directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      rnd_reg   <= '0;
      state_reg <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= data_in ^ key[LEN_KEY-1 -: 128];
            rnd_reg   <= '0;
            fsm_reg   <= RUN;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= round_next;
          rnd_reg   <= rnd_reg + STEP;
          if (rnd_reg == LAST) begin
            fsm_reg   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_reg   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm_reg   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = state_reg;

endmodule
